alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle radix-2 shift-add multiplier for the RV64M execute stage.
- Covers MUL, MULH, MULHSU, MULHU and MULW.
- Sits beside the divide unit in the ALU and shares its operand conventions: `XLEN operands, signedness selects, and a 32-bit "W" mode.
- Uses a valid/ready request handshake in and a valid/ready result handshake out, so the pipeline can stall on it.

Parameters:
- XLEN, `XLEN (64): operand width.
- W_BITS, 32: operand width in word mode.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- mul_valid_i  input  1  request valid
- mul_ready_o  output  1  unit idle, can accept a request
- flush_i  input  1  abort any in-flight operation
- mulw_i  input  1  word mode (MULW)
- mul_signed_i  input  2  operand signedness: [1]=sr1 signed, [0]=sr2 signed; 2'b01 illegal, treated as 2'b00
- sr1_data_i  input  XLEN  multiplicand
- sr2_data_i  input  XLEN  multiplier
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer takes result
- mul_lo_o  output  XLEN  low half of product (MUL/MULW)
- mul_hi_o  output  XLEN  high half of product (MULH/MULHSU/MULHU)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- While rst is high, state goes to IDLE and every register clears: product, operands, counter, sign flag. out_valid_o=0, mul_lo_o=0, mul_hi_o=0.
- mul_ready_o = (state==IDLE). It reads 1 on the first cycle after rst deasserts.
- States and transitions:
  - IDLE -> BUSY on mul_valid_i && mul_ready_o (the accept edge).
  - BUSY -> DONE when the counter reaches 0.
  - DONE -> IDLE on out_ready_i.
  - Any state -> IDLE on flush_i. flush_i has priority over accept, step and out_ready_i; the result is discarded and out_valid_o is 0 the next cycle.
- Accept edge:
  - Word mode: operands are the low 32 bits, sign-extended per the sign bits, or zero-extended when unsigned.
  - Magnitudes |a| and |b| are stored.
  - neg = (a negative) XOR (b negative) is stored.
  - Counter loads XLEN, or 32 in word mode.
  - 2*XLEN product register clears.
- BUSY: each cycle examines one multiplier bit, LSB first. It adds the multiplicand into the upper half when the bit is 1, then shifts the product right one bit, and decrements the counter.
- Latency from accept edge to out_valid_o high is 64 cycles, or 32 in word mode. No early termination unless the Optional Feature is compiled in.
- DONE:
  - out_valid_o=1.
  - The result is the registered product, two's-complement negated over 2*XLEN bits when neg=1.
  - Outputs hold stable until out_ready_i.
  - out_ready_i in the same cycle out_valid_o rises completes the transfer in one cycle.
  - A new request cannot be accepted in the DONE->IDLE transition cycle; minimum issue interval is latency+2.
- Outputs are 0 whenever out_valid_o=0.
- Word mode: mul_lo_o = sign-extend of product[31:0] to XLEN; mul_hi_o = 0.
- Boundary cases:
  - Most-negative signed operand: magnitude is 2^63 and is representable unsigned.
  - (-2^63)*(-1) gives hi=0, lo=0x8000000000000000.
  - No overflow flag.
- mul_valid_i while BUSY or DONE is ignored (not accepted).
- Reset mid-operation behaves the same as flush and clears all outputs.

Optional Feature:
- Macro: ALU_MUL_EARLY_ZERO_EN.
- When defined: on the accept edge, if either selected operand is zero, go IDLE -> DONE directly with product=0, so latency is 1 cycle.
- When undefined: zero operands take full latency. Results are identical either way.

Decomposition:
- Shared package (alongside sysconfig.v): state encodings MUL_IDLE/MUL_BUSY/MUL_DONE and signedness encodings MUL_SS=2'b11, MUL_SU=2'b10, MUL_UU=2'b00.
- Counter width: $clog2(XLEN)+1.
- One sub-module: alu_mul_signfix. It takes operand magnitude/sign on the input side and performs the conditional 2*XLEN negate on the output side, and is reused for both directions.

Test Plan:
- MULHU 0xFFFFFFFFFFFFFFFF*0xFFFFFFFFFFFFFFFF -> hi=0xFFFFFFFFFFFFFFFE, lo=0x0000000000000001. out_valid_o exactly 64 cycles after accept.
- MULH signed -1*-1 -> hi=0, lo=1. MULH -2^63*-1 -> hi=0, lo=0x8000000000000000.
- MULHSU -1 (signed) * 0xFFFFFFFFFFFFFFFF (unsigned) -> hi=0xFFFFFFFFFFFFFFFF, lo=0x0000000000000001.
- MULW 0x7FFFFFFF*2 -> lo=0xFFFFFFFFFFFFFFFE, hi=0; out_valid_o 32 cycles after accept. Upper operand bits set to 0xDEADBEEF must not affect the result.
- Handshake:
  - Hold out_ready_i=0 for 10 cycles in DONE; outputs stay stable.
  - mul_valid_i during BUSY is not accepted.
  - flush_i at BUSY cycle 20 -> IDLE next cycle, out_valid_o never rises.
  - rst mid-BUSY -> all outputs 0 and mul_ready_o=1 after release.
- With ALU_MUL_EARLY_ZERO_EN: 0*0x1234 -> out_valid_o 1 cycle after accept with hi=lo=0. Without it: 64 cycles, same values.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// ============================================================================
// Module      : alu_mul_seq_pkg
// Description : Shared state and signedness encodings for the shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 64
`endif

package alu_mul_seq_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    localparam logic [1:0] MUL_SS = 2'b11;
    localparam logic [1:0] MUL_SU = 2'b10;
    localparam logic [1:0] MUL_UU = 2'b00;

    // Returns {sr1 signed, sr2 signed}; the illegal 2'b01 collapses to unsigned*unsigned.
    function automatic logic [1:0] mul_sign_sel(input logic [1:0] sel);
        case (sel)
            MUL_SS:  return 2'b11;
            MUL_SU:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_signfix.sv
// ============================================================================
// Module      : alu_mul_signfix
// Description : Conditional two's-complement negate; yields operand magnitudes
//               and re-applies the product sign.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_signfix #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
// Module      : alu_mul_seq
// Description : Radix-2 shift-add multiplier (MUL/MULH/MULHSU/MULHU/MULW).
//               Define ALU_MUL_EARLY_ZERO_EN to bypass the iteration for
//               zero operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 64
`endif

module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int XLEN   = `XLEN,
    parameter int W_BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_valid_i,
    output logic            mul_ready_o,
    input  logic            flush_i,
    input  logic            mulw_i,
    input  logic [1:0]      mul_signed_i,
    input  logic [XLEN-1:0] sr1_data_i,
    input  logic [XLEN-1:0] sr2_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] mul_lo_o,
    output logic [XLEN-1:0] mul_hi_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    mul_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0]       mcand_q, mcand_d;
    logic [XLEN-1:0]       mplier_q, mplier_d;
    logic [2*XLEN-1:0]     prod_q, prod_d;
    logic                  neg_q, neg_d;
    logic                  word_q, word_d;

    logic [1:0]            w_sgn;
    logic [XLEN-1:0]       w_a_ext, w_b_ext;
    logic                  w_a_neg, w_b_neg;
    logic [XLEN-1:0]       w_a_mag, w_b_mag;
    logic [XLEN:0]         w_sum;
    logic [2*XLEN-1:0]     w_prod_step;
    logic [2*XLEN-1:0]     w_prod_aligned;
    logic [2*XLEN-1:0]     w_res;

    assign w_sgn = mul_sign_sel(mul_signed_i);

    always_comb begin
        if (mulw_i) begin
            w_a_ext = w_sgn[1] ? {{(XLEN-W_BITS){sr1_data_i[W_BITS-1]}}, sr1_data_i[W_BITS-1:0]}
                               : {{(XLEN-W_BITS){1'b0}}, sr1_data_i[W_BITS-1:0]};
            w_b_ext = w_sgn[0] ? {{(XLEN-W_BITS){sr2_data_i[W_BITS-1]}}, sr2_data_i[W_BITS-1:0]}
                               : {{(XLEN-W_BITS){1'b0}}, sr2_data_i[W_BITS-1:0]};
        end else begin
            w_a_ext = sr1_data_i;
            w_b_ext = sr2_data_i;
        end
    end

    assign w_a_neg = w_sgn[1] & w_a_ext[XLEN-1];
    assign w_b_neg = w_sgn[0] & w_b_ext[XLEN-1];

    alu_mul_signfix #(.WIDTH(XLEN)) u_fix_a (
        .val_i (w_a_ext),
        .neg_i (w_a_neg),
        .val_o (w_a_mag)
    );

    alu_mul_signfix #(.WIDTH(XLEN)) u_fix_b (
        .val_i (w_b_ext),
        .neg_i (w_b_neg),
        .val_o (w_b_mag)
    );

    // The extra sum bit carries the add overflow into the shifted product.
    assign w_sum       = mplier_q[0] ? ({1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q})
                                     : {1'b0, prod_q[2*XLEN-1:XLEN]};
    assign w_prod_step = {w_sum, prod_q[XLEN-1:1]};

    // Word mode runs only W_BITS steps, leaving the product XLEN-W_BITS bits too high.
    assign w_prod_aligned = word_q ? (prod_q >> (XLEN - W_BITS)) : prod_q;

    alu_mul_signfix #(.WIDTH(2*XLEN)) u_fix_res (
        .val_i (w_prod_aligned),
        .neg_i (neg_q),
        .val_o (w_res)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        word_d   = word_q;
        case (state_q)
            MUL_IDLE: begin
                if (mul_valid_i) begin
                    state_d  = MUL_BUSY;
                    cnt_d    = mulw_i ? CNT_W'(W_BITS) : CNT_W'(XLEN);
                    mcand_d  = w_a_mag;
                    mplier_d = w_b_mag;
                    neg_d    = w_a_neg ^ w_b_neg;
                    word_d   = mulw_i;
                    prod_d   = '0;
`ifdef ALU_MUL_EARLY_ZERO_EN
                    if ((w_a_ext == '0) || (w_b_ext == '0)) begin
                        state_d = MUL_DONE;
                        cnt_d   = '0;
                        neg_d   = 1'b0;
                    end
`endif
                end
            end
            MUL_BUSY: begin
                prod_d   = w_prod_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                if (out_ready_i) begin
                    state_d = MUL_IDLE;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
        if (flush_i) begin
            state_d = MUL_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            word_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            word_q   <= word_d;
        end
    end

    assign mul_ready_o = (state_q == MUL_IDLE);
    assign out_valid_o = (state_q == MUL_DONE);

    always_comb begin
        mul_lo_o = '0;
        mul_hi_o = '0;
        if (out_valid_o) begin
            if (word_q) begin
                mul_lo_o = {{(XLEN-W_BITS){w_res[W_BITS-1]}}, w_res[W_BITS-1:0]};
            end else begin
                mul_lo_o = w_res[XLEN-1:0];
                mul_hi_o = w_res[2*XLEN-1:XLEN];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// ============================================================================
// Module      : tb_alu_mul_seq
// Description : Self-checking bench for alu_mul_seq: directed vector table,
//               handshake corner sequences and randomized model comparison.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_valid;
    logic        mul_ready;
    logic        flush;
    logic        mulw;
    logic [1:0]  mul_signed;
    logic [63:0] sr1, sr2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] mul_lo, mul_hi;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk          (clk),
        .rst          (rst),
        .mul_valid_i  (mul_valid),
        .mul_ready_o  (mul_ready),
        .flush_i      (flush),
        .mulw_i       (mulw),
        .mul_signed_i (mul_signed),
        .sr1_data_i   (sr1),
        .sr2_data_i   (sr2),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .mul_lo_o     (mul_lo),
        .mul_hi_o     (mul_hi)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  sg;
        logic        w;
        logic [63:0] hi;
        logic [63:0] lo;
        int          lat;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference: extend each operand to 128 bits by its signedness and multiply.
    function automatic void ref_mul(input logic [63:0] a, input logic [63:0] b,
                                    input logic [1:0] sg, input logic w,
                                    output logic [63:0] hi, output logic [63:0] lo,
                                    output int lat);
        logic         as, bs;
        logic [127:0] ax, bx, p;
        as = (sg == 2'b11) || (sg == 2'b10);
        bs = (sg == 2'b11);
        if (w) begin
            a = as ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
            b = bs ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
        end
        ax = as ? {{64{a[63]}}, a} : {64'd0, a};
        bx = bs ? {{64{b[63]}}, b} : {64'd0, b};
        p  = ax * bx;
        if (w) begin
            hi = 64'd0;
            lo = {{32{p[31]}}, p[31:0]};
        end else begin
            hi = p[127:64];
            lo = p[63:0];
        end
        lat = w ? 32 : 64;
`ifdef ALU_MUL_EARLY_ZERO_EN
        // Result visible right after the accept edge.
        if (a == 64'd0 || b == 64'd0) lat = 0;
`endif
    endfunction

    // Called just after a posedge with the DUT idle; lat counts edges after the accept edge.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg,
                          input logic w, output logic [63:0] hi, output logic [63:0] lo,
                          output int lat);
        sr1 = a; sr2 = b; mul_signed = sg; mulw = w; mul_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        mul_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        hi = mul_hi;
        lo = mul_lo;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic wait_no_valid(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk(name, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        logic [63:0] hi, lo, ehi, elo, a, b;
        logic [1:0]  sg;
        logic        w;
        int          lat, elat;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001, 64};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0,
                    64'd0, 64'd1, 64};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0,
                    64'd0, 64'h8000_0000_0000_0000, 64};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64};
        vecs[4] = '{64'hDEAD_BEEF_7FFF_FFFF, 64'hDEAD_BEEF_0000_0002, 2'b00, 1'b1,
                    64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 32};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001, 64};
`ifdef ALU_MUL_EARLY_ZERO_EN
        vecs[6] = '{64'd0, 64'h1234, 2'b00, 1'b0, 64'd0, 64'd0, 0};
`else
        vecs[6] = '{64'd0, 64'h1234, 2'b00, 1'b0, 64'd0, 64'd0, 64};
`endif
        vecs[7] = '{64'h1234_5678_FFFF_FFFF, 64'h0000_0000_0000_0003, 2'b11, 1'b1,
                    64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 32};
        vecs[8] = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 2'b11, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 64};

        rst = 1'b1; mul_valid = 1'b0; flush = 1'b0; mulw = 1'b0; mul_signed = 2'b00;
        sr1 = 64'd0; sr2 = 64'd0; out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_lo", mul_lo, 64'd0);
        chk("rst_hi", mul_hi, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready_after", {63'd0, mul_ready}, 64'd1);

        // Directed vectors
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].w, hi, lo, lat);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Outputs hold while the consumer stalls in DONE
        sr1 = 64'd6; sr2 = 64'd7; mul_signed = 2'b00; mulw = 1'b0; mul_valid = 1'b1;
        @(posedge clk); #1;
        mul_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("hold_lat", 64'(lat), 64'd64);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_lo", k), mul_lo, 64'd42);
            chk($sformatf("hold%0d_valid", k), {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold_release_valid", {63'd0, out_valid}, 64'd0);
        chk("hold_release_lo", mul_lo, 64'd0);

        // Requests while BUSY are ignored
        sr1 = 64'd5; sr2 = 64'd7; mul_valid = 1'b1;
        @(posedge clk); #1;
        sr1 = 64'd1000; sr2 = 64'd1000;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
        end
        chk("busy_ready", {63'd0, mul_ready}, 64'd0);
        mul_valid = 1'b0;
        lat = 20;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("busy_ignore_lat", 64'(lat), 64'd64);
        chk("busy_ignore_lo", mul_lo, 64'd35);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Flush at BUSY cycle 20
        sr1 = 64'd9; sr2 = 64'd9; mul_valid = 1'b1;
        @(posedge clk); #1;
        mul_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ready", {63'd0, mul_ready}, 64'd1);
        wait_no_valid("flush_no_valid", 80);

        // Reset mid-BUSY
        sr1 = 64'd11; sr2 = 64'd13; mul_valid = 1'b1;
        @(posedge clk); #1;
        mul_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_lo", mul_lo, 64'd0);
        chk("midrst_hi", mul_hi, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready", {63'd0, mul_ready}, 64'd1);
        wait_no_valid("midrst_no_valid", 70);
        run_op(64'd11, 64'd13, 2'b00, 1'b0, hi, lo, lat);
        chk("post_rst_lo", lo, 64'd143);

        // Randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if ((i % 8) == 3) a = 64'd0;
            if ((i % 8) == 5) b = {32'hFFFF_FFFF, 32'h8000_0000};
            if ((i % 8) == 6) a = 64'h8000_0000_0000_0000;
            sg = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            ref_mul(a, b, sg, w, ehi, elo, elat);
            run_op(a, b, sg, w, hi, lo, lat);
            chk($sformatf("rnd%0d_hi", i), hi, ehi);
            chk($sformatf("rnd%0d_lo", i), lo, elo);
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(elat));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
